// File: rtl/tt_um_deserialize_if.sv
// Serial-result input bus and parallel-word readout bus of the deserializer.
// The master drives the bit streams and ready. The slave (the deserializer) drives the words, valid and status.
interface tt_um_deserialize_if #(
  parameter int MAX_OUT_LEN = 12,
  parameter int ACC_WIDTH   = 8
);
  logic                             ui_lsb_select;
  logic [7:0]                       ui_bit_select;
  logic [MAX_OUT_LEN-1:0]           ui_bits;
  logic                             ui_relu;
  logic [ACC_WIDTH*MAX_OUT_LEN-1:0] uo_data;
  logic                             uo_valid;
  logic                             ui_ready;
  logic                             uo_overrun;
  logic                             uo_abort;

  modport master (
    output ui_lsb_select, ui_bit_select, ui_bits, ui_relu, ui_ready,
    input  uo_data, uo_valid, uo_overrun, uo_abort
  );

  modport slave (
    input  ui_lsb_select, ui_bit_select, ui_bits, ui_relu, ui_ready,
    output uo_data, uo_valid, uo_overrun, uo_abort
  );
endinterface

// File: rtl/tt_um_deserialize.sv
// Collects LSB-first per-lane bit streams into signed ACC_WIDTH words (sign-extend/saturate, optional ReLU).
// Result is visible L cycles after bit 0. A full single-entry buffer drops the new word and sets sticky overrun.
module tt_um_deserialize #(
  parameter int MAX_OUT_LEN = 12,
  parameter int ACC_WIDTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  tt_um_deserialize_if.slave  bus
);
  typedef enum logic {IDLE, SHIFT} state_e;
  typedef logic [MAX_OUT_LEN-1:0][ACC_WIDTH-1:0] words_t;

  state_e                 state_q, state_d;
  logic [7:0]             count_q, count_d;
  logic [7:0]             len_q, len_d;
  logic                   relu_q, relu_d;
  words_t                 sreg_q, sreg_d, res;
  logic [MAX_OUT_LEN-1:0] seen1_q, seen1_d, seen0_q, seen0_d;
  words_t                 data_q;
  logic                   valid_q, overrun_q, abort_q;
  logic                   capture, clear, done, abort_d;
  logic [7:0]             k;
  logic                   sbit;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    relu_d  = relu_q;
    capture = 1'b0;
    clear   = 1'b0;
    done    = 1'b0;
    abort_d = 1'b0;
    k       = count_q + 8'd1;
    // A strobe always starts a fresh word, abandoning any partial one.
    if (bus.ui_lsb_select) begin
      capture = 1'b1;
      clear   = 1'b1;
      k       = 8'd0;
      count_d = 8'd0;
      len_d   = bus.ui_bit_select;
      relu_d  = bus.ui_relu;
      abort_d = (state_q == SHIFT);
      if (bus.ui_bit_select == 8'd0) begin
        done    = 1'b1;
        state_d = IDLE;
      end else begin
        state_d = SHIFT;
      end
    end else if (state_q == SHIFT) begin
      capture = 1'b1;
      count_d = k;
      if (k == len_q) begin
        done    = 1'b1;
        state_d = IDLE;
      end
    end
  end

  // Result is formed from the next-state lane registers so completion needs no extra cycle.
  always_comb begin
    sreg_d  = clear ? '0 : sreg_q;
    seen1_d = clear ? '0 : seen1_q;
    seen0_d = clear ? '0 : seen0_q;
    res     = '0;
    sbit    = 1'b0;
    for (int i = 0; i < MAX_OUT_LEN; i++) begin
      if (capture) begin
        for (int j = 0; j < ACC_WIDTH; j++) begin
          if (32'(k) == j) sreg_d[i][j] = bus.ui_bits[i];
        end
        if (32'(k) >= ACC_WIDTH - 1) begin
          seen1_d[i] = seen1_d[i] | bus.ui_bits[i];
          seen0_d[i] = seen0_d[i] | ~bus.ui_bits[i];
        end
      end
      if (32'(len_d) < ACC_WIDTH) begin
        sbit = 1'b0;
        for (int j = 0; j < ACC_WIDTH; j++) begin
          if (32'(len_d) == j) sbit = sreg_d[i][j];
        end
        for (int j = 0; j < ACC_WIDTH; j++) begin
          res[i][j] = (j <= 32'(len_d)) ? sreg_d[i][j] : sbit;
        end
      end else if (!bus.ui_bits[i] && seen1_d[i]) begin
        res[i] = {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else if (bus.ui_bits[i] && seen0_d[i]) begin
        res[i] = {1'b1, {(ACC_WIDTH-1){1'b0}}};
      end else begin
        res[i] = sreg_d[i];
      end
      if (relu_d && res[i][ACC_WIDTH-1]) res[i] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= 8'd0;
      len_q     <= 8'd0;
      relu_q    <= 1'b0;
      sreg_q    <= '0;
      seen1_q   <= '0;
      seen0_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      relu_q  <= relu_d;
      sreg_q  <= sreg_d;
      seen1_q <= seen1_d;
      seen0_q <= seen0_d;
      abort_q <= abort_d;
      if (done) begin
        if (!valid_q || bus.ui_ready) begin
          data_q  <= res;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && bus.ui_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.uo_data    = data_q;
  assign bus.uo_valid   = valid_q;
  assign bus.uo_overrun = overrun_q;
  assign bus.uo_abort   = abort_q;
endmodule

// File: tb/tb_tt_um_deserialize.sv
// Directed bench: stimulus pushes hand-computed words to a queue; a negedge monitor compares each accepted word.
module tb_tt_um_deserialize;
  localparam int N = 12;
  localparam int W = 8;
  typedef logic [N-1:0][W-1:0] word_t;
  typedef logic [N-1:0][15:0]  vals_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tt_um_deserialize_if #(.MAX_OUT_LEN(N), .ACC_WIDTH(W)) bus ();

  tt_um_deserialize #(.MAX_OUT_LEN(N), .ACC_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    checks   = 0;
  int    failures = 0;
  word_t exp_q[$];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  always @(negedge clk) begin
    word_t e;
    if (!rst && bus.uo_valid && bus.ui_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output got=%0h exp=none", bus.uo_data);
      end else begin
        e = exp_q.pop_front();
        check("output_data", 128'(bus.uo_data), 128'(e));
      end
    end
  end

  task automatic drive_cycle(input logic lsb, input logic [7:0] bsel, input logic relu,
                             input logic [N-1:0] bits);
    @(posedge clk);
    #1;
    bus.ui_lsb_select = lsb;
    bus.ui_bit_select = bsel;
    bus.ui_relu       = relu;
    bus.ui_bits       = bits;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) drive_cycle(1'b0, 8'd0, 1'b0, '0);
  endtask

  function automatic logic [N-1:0] lane_bits(input vals_t v, input int k);
    logic [N-1:0] b;
    for (int i = 0; i < N; i++) b[i] = v[i][k];
    return b;
  endfunction

  task automatic send_frame(input int len, input vals_t v, input logic relu);
    for (int k = 0; k < len; k++) drive_cycle(k == 0, 8'(len - 1), relu, lane_bits(v, k));
  endtask

  initial begin
    vals_t v, v2;
    word_t e, e2;
    bus.ui_lsb_select = 1'b0;
    bus.ui_bit_select = 8'd0;
    bus.ui_bits       = '0;
    bus.ui_relu       = 1'b0;
    bus.ui_ready      = 1'b1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("reset_idle", 128'({bus.uo_valid, bus.uo_overrun, bus.uo_abort, bus.uo_data}), 128'd0);
    end

    // In-range word, L=4, with latency and valid-drop checks
    v = '0; v[0] = 16'hFFFD; v[1] = 16'h0003;
    e = '0; e[0] = 8'hFD; e[1] = 8'h03;
    exp_q.push_back(e);
    send_frame(4, v, 1'b0);
    @(negedge clk) check("latency_early", 128'(bus.uo_valid), 128'd0);
    idle(1);
    @(negedge clk) check("latency_valid", 128'(bus.uo_valid), 128'd1);
    @(negedge clk) check("valid_drop", 128'(bus.uo_valid), 128'd0);

    // Saturation and boundary values, L=12
    v = '0;
    v[0] = 16'd300;  v[1] = 16'hFED4; v[2] = 16'd100; v[3] = 16'hFF9C;
    v[4] = 16'd127;  v[5] = 16'd128;  v[6] = 16'hFF7F; v[7] = 16'hFF80;
    e = '0;
    e[0] = 8'h7F; e[1] = 8'h80; e[2] = 8'h64; e[3] = 8'h9C;
    e[4] = 8'h7F; e[5] = 8'h7F; e[6] = 8'h80; e[7] = 8'h80;
    exp_q.push_back(e);
    send_frame(12, v, 1'b0);
    idle(2);

    // ReLU
    v = '0; v[0] = 16'hFFFD; v[1] = 16'd5; v[2] = 16'hFFF8;
    e = '0; e[1] = 8'h05;
    exp_q.push_back(e);
    send_frame(4, v, 1'b1);
    idle(2);

    // L=1, L=8 and L=9 boundaries
    v = '0; v[0] = 16'hFFFF;
    e = '0; e[0] = 8'hFF;
    exp_q.push_back(e);
    send_frame(1, v, 1'b0);
    idle(2);
    v = '0; v[0] = 16'hFF80; v[1] = 16'd127; v[2] = 16'hFFFF;
    e = '0; e[0] = 8'h80; e[1] = 8'h7F; e[2] = 8'hFF;
    exp_q.push_back(e);
    send_frame(8, v, 1'b0);
    idle(2);
    v = '0; v[0] = 16'd255; v[1] = 16'hFFFF; v[2] = 16'hFF00;
    e = '0; e[0] = 8'h7F; e[1] = 8'hFF; e[2] = 8'h80;
    exp_q.push_back(e);
    send_frame(9, v, 1'b0);
    idle(2);

    // Back-to-back frames with ready high
    v  = '0; v[0]  = 16'd5;    v[1]  = 16'hFFF8;
    e  = '0; e[0]  = 8'h05;    e[1]  = 8'hF8;
    v2 = '0; v2[0] = 16'hFFFE; v2[1] = 16'd7;
    e2 = '0; e2[0] = 8'hFE;    e2[1] = 8'h07;
    exp_q.push_back(e);
    exp_q.push_back(e2);
    send_frame(4, v, 1'b0);
    send_frame(4, v2, 1'b0);
    idle(2);
    check("b2b_drained", 128'(exp_q.size()), 128'd0);

    // Back-pressure: first held, second dropped
    bus.ui_ready = 1'b0;
    v  = '0; v[0]  = 16'd2;
    e  = '0; e[0]  = 8'h02;
    v2 = '0; v2[0] = 16'hFFFF;
    exp_q.push_back(e);
    send_frame(4, v, 1'b0);
    send_frame(4, v2, 1'b0);
    idle(2);
    @(negedge clk);
    check("bp_valid_held", 128'(bus.uo_valid), 128'd1);
    check("bp_overrun_set", 128'(bus.uo_overrun), 128'd1);
    @(posedge clk);
    #1 bus.ui_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_clear", 128'(bus.uo_valid), 128'd0);
    check("bp_overrun_sticky", 128'(bus.uo_overrun), 128'd1);

    // Early restart at bit 3 of an L=8 word
    v = '0; v[0] = 16'h0055; v[1] = 16'h00AA;
    for (int k = 0; k < 3; k++) drive_cycle(k == 0, 8'd7, 1'b0, lane_bits(v, k));
    v2 = '0; v2[0] = 16'hFF9C; v2[1] = 16'd77;
    e2 = '0; e2[0] = 8'h9C;    e2[1] = 8'h4D;
    exp_q.push_back(e2);
    for (int k = 0; k < 8; k++) begin
      drive_cycle(k == 0, 8'd7, 1'b0, lane_bits(v2, k));
      @(negedge clk);
      if (k == 0) check("abort_before", 128'(bus.uo_abort), 128'd0);
      if (k == 1) check("abort_pulse", 128'(bus.uo_abort), 128'd1);
      if (k == 2) check("abort_after", 128'(bus.uo_abort), 128'd0);
      if (k == 7) check("restart_early", 128'(bus.uo_valid), 128'd0);
    end
    idle(1);
    @(negedge clk) check("restart_valid", 128'(bus.uo_valid), 128'd1);
    idle(2);

    // Reset asserted at bit 5 of an L=8 word
    v = '0; v[0] = 16'h0033; v[3] = 16'h00C7;
    for (int k = 0; k < 8; k++) begin
      drive_cycle(k == 0, 8'd7, 1'b0, lane_bits(v, k));
      if (k == 5) rst = 1'b1;
    end
    idle(1);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("post_reset", 128'({bus.uo_valid, bus.uo_overrun, bus.uo_abort, bus.uo_data}), 128'd0);
    end

    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tt_um_deserialize.md
# tt_um_deserialize

Downstream of the bit-serial ternary multiplier, this block turns the per-output result bit streams into parallel signed words. It collects one bit per output per cycle, LSB first, framed by the multiplier's LSB-select strobe. Each completed word set is sign-extended or saturated to `ACC_WIDTH` bits and optionally clamped by ReLU. The result is held in a single-entry output register with a valid/ready handshake, for the top-level readout mux.

## Interface
Parameters:
- `MAX_OUT_LEN`, 12, number of parallel output lanes (one serial bit each).
- `ACC_WIDTH`, 8, width of each deserialized signed word; must be ≥ 2.

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ui_lsb_select`  in  1  high on the cycle carrying bit 0 of a new word.
- `ui_bit_select`  in  8  word length minus one (L = value+1, 1..256); sampled only when `ui_lsb_select` is high.
- `ui_bits`  in  MAX_OUT_LEN  one serial result bit per lane; two's complement, LSB first.
- `ui_relu`  in  1  when high, negative results are replaced by 0; sampled with `ui_lsb_select`.
- `uo_data`  out  ACC_WIDTH*MAX_OUT_LEN  lane i at bits [i*ACC_WIDTH +: ACC_WIDTH].
- `uo_valid`  out  1  `uo_data` holds an unconsumed result.
- `ui_ready`  in  1  consumer accepts `uo_data` on a cycle where `uo_valid & ui_ready`.
- `uo_overrun`  out  1  sticky; a completed word was dropped because the buffer was full.
- `uo_abort`  out  1  one-cycle pulse; a partial word was discarded by an early `ui_lsb_select`.

## Operation
- States: IDLE, SHIFT.
- IDLE with `ui_lsb_select`=1:
  - latch L, latch relu mode, clear per-lane shift registers and flags, capture bit 0.
  - count←0; go to SHIFT, or complete immediately if L=1.
- SHIFT: each cycle capture bit k = count+1 and increment count. The word completes on the cycle bit L-1 is captured; the next state is IDLE.
- Capture, per lane:
  - bit k < ACC_WIDTH is written into position k.
  - For every bit with k ≥ ACC_WIDTH-1, update `seen1` or `seen0`.
- Completion, per lane (s = last bit received):
  - L ≤ ACC_WIDTH: sign-extend from bit L-1.
  - L > ACC_WIDTH: if s=0 and `seen1`, saturate to +(2^(ACC_WIDTH-1)-1). If s=1 and `seen0`, saturate to −2^(ACC_WIDTH-1). Otherwise take the low ACC_WIDTH bits.
  - Then if relu is set and the result is negative, output 0.
- Early restart: `ui_lsb_select`=1 in SHIFT before the final bit abandons the partial word, pulses `uo_abort`, and starts a new word with this cycle's bit 0.
- A `ui_lsb_select` on the cycle after completion is the normal back-to-back case; no gap is required.
- Output buffer:
  - On completion with buffer empty, or with `uo_valid & ui_ready` the same cycle: load `uo_data` and set `uo_valid`.
  - On completion with `uo_valid & !ui_ready`: discard the new result, keep the old one, set `uo_overrun`.
  - `uo_valid & ui_ready` without completion clears `uo_valid`. `uo_data` keeps its last value.
- `uo_overrun` clears only on `rst`.

## Timing
- Reset values:
  - `uo_data`=0, `uo_valid`=0, `uo_overrun`=0, `uo_abort`=0.
  - State IDLE; count=0.
- Latency: with bit 0 presented at cycle 0, `uo_valid` rises and `uo_data` is updated at the clock edge ending cycle L-1, so they are visible in cycle L.
- Throughput: one word set per L cycles with back-to-back frames.
- `uo_abort` is registered and is high for exactly the cycle after the restart edge.
- Reset asserted mid-word or mid-handshake clears everything immediately. The first frame after deassertion needs a fresh `ui_lsb_select`.
- `ui_bits` is ignored in IDLE when `ui_lsb_select`=0.
- `ui_bit_select` changes mid-word have no effect.

## Test plan
- Reset then idle: `rst` pulse, no strobes for 20 cycles -> all outputs 0, `uo_valid` stays 0.
- In-range word: ACC_WIDTH=8, L=4, lane 0 bits 1,0,1,1 (−3), lane 1 bits 1,1,0,0 (+3), `ui_ready`=1 -> in cycle 4 `uo_valid`=1, lane0=0xFD, lane1=0x03, and `uo_valid` drops the next cycle.
- Saturation: L=12, lane 0 = +300, lane 1 = −300, lane 2 = +100 -> lane0=0x7F, lane1=0x80, lane2=0x64.
- ReLU: L=4 with lane 0 = −3, lane 1 = +5, `ui_relu`=1 -> lane0=0x00, lane1=0x05.
- Back-pressure:
  - `ui_ready`=0, two back-to-back L=4 frames -> the first result is held, the second is dropped, `uo_overrun`=1.
  - Then raise `ui_ready` -> the first result is accepted, `uo_valid`=0, `uo_overrun` stays 1.
- Early restart and reset: L=8, strobe again at bit 3 -> one-cycle `uo_abort`, and the new word completes 8 cycles after the restart. Asserting `rst` at bit 5 of a later word produces no `uo_valid`.
